// File: rtl/kernel_result_monitor_if.sv
// Result channel between the kernel's out0 port and kernel_result_monitor.
// master: the kernel side (drives data/valid). slave: the monitor (drives ready).
interface kernel_result_monitor_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/kernel_result_monitor.sv
// kernel_result_monitor: terminal stage of the single-shot kernel.
// Detects the start handshake and accepts exactly one result token.
// Measures the start-to-result latency in cycles.
// Flags early and extra tokens, and times out if no result arrives.
// Optional feature macro: MONITOR_BP_LFSR_EN adds pseudo-random
// backpressure in RUN, driven by an 8-bit LFSR and gated by bp_en.
module kernel_result_monitor #(
  parameter int DATA_W  = 10,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_fire,
  input  logic                   soft_clr,
  input  logic                   bp_en,
  kernel_result_monitor_if.slave bus,
  output logic [DATA_W-1:0]      result,
  output logic [CNT_W-1:0]       latency,
  output logic                   done,
  output logic                   timeout,
  output logic                   err_early,
  output logic                   err_extra
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_TOUT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;
  logic             accept;

`ifdef MONITOR_BP_LFSR_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; only rst reseeds it, soft_clr does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Ready depends only on registered state and the LFSR; backpressure applies in RUN only.
  always_comb begin
    bus.in_ready = 1'b1;
    if (state == ST_RUN) begin
      bus.in_ready = ~bp_en | lfsr[0];
    end
  end
`else
  logic unused_bp_en;
  assign unused_bp_en = bp_en;

  // Ready is held high in every state when backpressure is not built in.
  always_comb begin
    bus.in_ready = 1'b1;
  end
`endif

  assign accept = bus.in_valid & bus.in_ready;

  // Main FSM with registered outputs; soft_clr drops any token accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || soft_clr) begin
      state     <= ST_IDLE;
      result    <= '0;
      latency   <= '0;
      lat_cnt   <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_early <= 1'b0;
      err_extra <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_fire && accept) begin
            result  <= bus.in_data;
            latency <= '0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else if (start_fire) begin
            lat_cnt <= ONE_C;
            state   <= ST_RUN;
          end else if (accept) begin
            err_early <= 1'b1;
          end
        end
        ST_RUN: begin
          // An acceptance on the TIMEOUT cycle takes priority over the timeout.
          if (accept) begin
            result  <= bus.in_data;
            latency <= lat_cnt;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else if (lat_cnt == TIMEOUT_C) begin
            timeout <= 1'b1;
            state   <= ST_TOUT;
          end else begin
            lat_cnt <= lat_cnt + ONE_C;
          end
        end
        ST_DONE: begin
          if (accept) begin
            err_extra <= 1'b1;
          end
        end
        ST_TOUT: begin
          if (accept) begin
            result    <= bus.in_data;
            err_extra <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_result_monitor.sv
// Directed bench for kernel_result_monitor with TIMEOUT=16.
// Inputs are driven 1ns after each rising edge, and outputs are sampled at the same point.
module tb_kernel_result_monitor;
  localparam int DATA_W  = 10;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_fire = 1'b0;
  logic              soft_clr = 1'b0;
  logic              bp_en = 1'b0;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  latency;
  logic              done;
  logic              timeout;
  logic              err_early;
  logic              err_extra;

  int tests = 0;
  int fails = 0;

  kernel_result_monitor_if #(.DATA_W(DATA_W)) bus ();

  kernel_result_monitor #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_fire(start_fire),
    .soft_clr  (soft_clr),
    .bp_en     (bp_en),
    .bus       (bus),
    .result    (result),
    .latency   (latency),
    .done      (done),
    .timeout   (timeout),
    .err_early (err_early),
    .err_extra (err_extra)
  );

  always #5 clk = ~clk;

  // Observation vector: {result, latency, done, timeout, err_early, err_extra}.
  logic [45:0] obs;
  assign obs = {result, latency, done, timeout, err_early, err_extra};

  // Reference LFSR (x^8+x^6+x^5+x^4+1, seed A5 on rst).
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear();
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    tick(2);
    tests++;
    if (obs !== 46'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 46'd0);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear();
    start_fire = 1'b1;
    tick();
    start_fire = 1'b0;
    tick(6);
    tests++;
    if (obs !== {10'h000, 32'd0, 4'b0000}) begin
      fails++;
      $display("FAIL basic_pending: got %h expected %h", obs, {10'h000, 32'd0, 4'b0000});
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h155;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h155, 32'd7, 4'b1000}) begin
      fails++;
      $display("FAIL basic_result: got %h expected %h", obs, {10'h155, 32'd7, 4'b1000});
    end
  endtask

  task automatic test_same_cycle();
    clear();
    start_fire   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h3FF;
    tick();
    start_fire   = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h3FF, 32'd0, 4'b1000}) begin
      fails++;
      $display("FAIL same_cycle: got %h expected %h", obs, {10'h3FF, 32'd0, 4'b1000});
    end
  endtask

  task automatic test_early();
    clear();
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h001;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h000, 32'd0, 4'b0010}) begin
      fails++;
      $display("FAIL early_flag: got %h expected %h", obs, {10'h000, 32'd0, 4'b0010});
    end
    start_fire = 1'b1;
    tick();
    start_fire = 1'b0;
    tick(2);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h002;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h002, 32'd3, 4'b1010}) begin
      fails++;
      $display("FAIL early_result: got %h expected %h", obs, {10'h002, 32'd3, 4'b1010});
    end
  endtask

  task automatic test_timeout();
    clear();
    start_fire = 1'b1;
    tick();
    start_fire = 1'b0;
    tick(15);
    tests++;
    if (obs !== {10'h000, 32'd0, 4'b0000}) begin
      fails++;
      $display("FAIL timeout_early: got %h expected %h", obs, {10'h000, 32'd0, 4'b0000});
    end
    tick();
    tests++;
    if (obs !== {10'h000, 32'd0, 4'b0100}) begin
      fails++;
      $display("FAIL timeout_set: got %h expected %h", obs, {10'h000, 32'd0, 4'b0100});
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h0AA;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h0AA, 32'd0, 4'b0101}) begin
      fails++;
      $display("FAIL timeout_late: got %h expected %h", obs, {10'h0AA, 32'd0, 4'b0101});
    end
  endtask

  task automatic test_timeout_edge();
    clear();
    start_fire = 1'b1;
    tick();
    start_fire = 1'b0;
    tick(15);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h2C4;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h2C4, 32'd16, 4'b1000}) begin
      fails++;
      $display("FAIL timeout_edge: got %h expected %h", obs, {10'h2C4, 32'd16, 4'b1000});
    end
  endtask

  task automatic test_extra_and_clear();
    clear();
    start_fire   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h2AB;
    tick();
    start_fire   = 1'b0;
    bus.in_data  = 10'h123;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h2AB, 32'd0, 4'b1001}) begin
      fails++;
      $display("FAIL extra_token: got %h expected %h", obs, {10'h2AB, 32'd0, 4'b1001});
    end
    start_fire = 1'b1;
    tick();
    start_fire = 1'b0;
    tests++;
    if (obs !== {10'h2AB, 32'd0, 4'b1001}) begin
      fails++;
      $display("FAIL done_start_ignored: got %h expected %h", obs, {10'h2AB, 32'd0, 4'b1001});
    end
    soft_clr     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h3C3;
    tick();
    soft_clr     = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== 46'd0) begin
      fails++;
      $display("FAIL soft_clr: got %h expected %h", obs, 46'd0);
    end
    start_fire = 1'b1;
    tick();
    start_fire   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h077;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h077, 32'd1, 4'b1000}) begin
      fails++;
      $display("FAIL rerun_after_clr: got %h expected %h", obs, {10'h077, 32'd1, 4'b1000});
    end
  endtask

  task automatic test_run_start_ignored();
    clear();
    start_fire = 1'b1;
    tick(2);
    start_fire   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h111;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h111, 32'd2, 4'b1000}) begin
      fails++;
      $display("FAIL run_start_ignored: got %h expected %h", obs, {10'h111, 32'd2, 4'b1000});
    end
  endtask

  task automatic test_rst_mid();
    clear();
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h005;
    tick();
    bus.in_valid = 1'b0;
    start_fire   = 1'b1;
    tick();
    start_fire = 1'b0;
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (obs !== 46'd0) begin
      fails++;
      $display("FAIL rst_mid: got %h expected %h", obs, 46'd0);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h00F;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h000, 32'd0, 4'b0010}) begin
      fails++;
      $display("FAIL rst_mid_idle: got %h expected %h", obs, {10'h000, 32'd0, 4'b0010});
    end
  endtask

`ifdef MONITOR_BP_LFSR_EN
  task automatic test_backpressure();
    int exp_k;
    bit acc;
    exp_k = 0;
    acc   = 1'b0;
    clear();
    bp_en      = 1'b1;
    start_fire = 1'b1;
    tick();
    start_fire   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h1C3;
    for (int k = 1; k <= TIMEOUT && !acc; k++) begin
      tests++;
      if (bus.in_ready !== m_lfsr[0]) begin
        fails++;
        $display("FAIL bp_ready k=%0d: got %b expected %b", k, bus.in_ready, m_lfsr[0]);
      end
      if (m_lfsr[0]) begin
        exp_k = k;
        acc   = 1'b1;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    tests++;
    if (acc) begin
      if (obs !== {10'h1C3, 32'(exp_k), 4'b1000}) begin
        fails++;
        $display("FAIL bp_accept: got %h expected %h", obs, {10'h1C3, 32'(exp_k), 4'b1000});
      end
    end else begin
      if (obs !== {10'h000, 32'd0, 4'b0100}) begin
        fails++;
        $display("FAIL bp_timeout: got %h expected %h", obs, {10'h000, 32'd0, 4'b0100});
      end
    end
    bp_en = 1'b0;
  endtask
`else
  task automatic test_backpressure();
    clear();
    bp_en      = 1'b1;
    start_fire = 1'b1;
    tick();
    start_fire = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ignored_ready: got %b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h1C3;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (obs !== {10'h1C3, 32'd1, 4'b1000}) begin
      fails++;
      $display("FAIL bp_ignored: got %h expected %h", obs, {10'h1C3, 32'd1, 4'b1000});
    end
    bp_en = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_basic();
    test_same_cycle();
    test_early();
    test_timeout();
    test_timeout_edge();
    test_extra_and_clear();
    test_run_start_ignored();
    test_rst_mid();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kernel_result_monitor.md
Name: kernel_result_monitor

Overview:
- Downstream consumer of the single-shot kernel top-level wrapper's result channel (out0/out0_valid/out0_ready).
- Detects the start handshake, accepts exactly one result token under elastic valid/ready rules, and measures start-to-result latency in cycles.
- Flags protocol errors (token before start, extra tokens) and timeouts.
- Used in simulation benches and FPGA bring-up as the terminal stage of the kernel.

Parameters:
DATA_W, 10, width of result token (matches kernel out0)
CNT_W, 32, width of latency counter
TIMEOUT, 4096, cycles in RUN without a result before declaring timeout (must be >=1, < 2^CNT_W)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start_fire  input  1  one-cycle pulse = kernel arg0_valid & arg0_ready & first-start
soft_clr  input  1  return to IDLE, clear captures/flags (same effect as rst except LFSR keeps running)
in_data  input  DATA_W  result token (kernel out0)
in_valid  input  1  kernel out0_valid
in_ready  output  1  drives kernel out0_ready
bp_en  input  1  enable pseudo-random backpressure (optional feature only)
result  output  DATA_W  captured token
latency  output  CNT_W  cycles from start_fire to result acceptance
done  output  1  result captured
timeout  output  1  timeout occurred
err_early  output  1  sticky: token accepted before start
err_extra  output  1  sticky: token accepted after done

Behaviour:
- Reset values: state=IDLE, result=0, latency=0, lat_cnt=0, done=0, timeout=0, err_early=0, err_extra=0.
- Handshake: a token is accepted when in_valid & in_ready on a rising edge.
- in_ready is a function of registered state (plus LFSR) only; no combinational path from in_valid.
- States:
  - IDLE: in_ready=1.
    - start_fire & accept (same cycle): result<=in_data, latency<=0, go DONE.
    - start_fire alone: lat_cnt<=1, go RUN.
    - accept without start_fire: err_early<=1, data discarded, stay IDLE.
  - RUN: in_ready=1 (see optional feature).
    - accept: result<=in_data, latency<=lat_cnt, go DONE.
    - else if lat_cnt==TIMEOUT: timeout<=1, go TOUT.
    - else lat_cnt<=lat_cnt+1.
    - Acceptance on the TIMEOUT cycle wins over timeout.
    - start_fire in RUN is ignored.
  - DONE: done=1, in_ready=1 (drain).
    - Any accept sets err_extra<=1; result/latency unchanged.
    - start_fire ignored.
  - TOUT: in_ready=1.
    - A late accept captures result, sets err_extra<=1, and does not set done; timeout stays 1.
- Latency is always taken from lat_cnt; the counter saturates at TIMEOUT, so no wrap occurs.
- soft_clr (highest priority after rst): go IDLE, clear all outputs and lat_cnt; the clear occurs even if a handshake occurs that cycle (token dropped, no flag).
- rst mid-operation: immediate IDLE, all outputs to reset values next cycle.

Optional Feature:
- Macro: MONITOR_BP_LFSR_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seeded 8'hA5 on rst, advances every cycle (soft_clr does not reseed).
  - In RUN, in_ready = ~bp_en | lfsr[0]; other states unchanged.
- Undefined: no LFSR, bp_en ignored, in_ready=1 in RUN.

Test Plan:
- start_fire at cycle 10, in_valid with in_data=10'h155 at cycle 17 -> done=1 at cycle 18, result=10'h155, latency=7, no flags.
- start_fire & in_valid (data 10'h3FF) in same cycle -> done=1 next cycle, latency=0, result=10'h3FF.
- in_valid before start_fire (data 10'h001), then start, then result 10'h002 after 3 cycles -> err_early=1, result=10'h002, latency=3.
- TIMEOUT=16, start, no token -> timeout=1 exactly 17 cycles after start_fire, done=0; a later token 10'h0AA -> result=10'h0AA, err_extra=1.
- After done, second token 10'h123 -> err_extra=1, result unchanged; soft_clr -> all outputs 0, state IDLE; new run works.
- With MONITOR_BP_LFSR_EN and bp_en=1, in_valid held from cycle 1 after start with data stable -> accept only on first cycle with lfsr[0]=1; latency equals that cycle index; in_data stable while stalled.
